// File: rtl/amns_bram_io_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : amns_bram_io_ctrl
// Purpose  : Design-side BRAM sequencer for the AMNS Montgomery multiplier.
//            On start it streams M'_0, M, A and B out of BRAM port B into
//            operand registers, kicks the multiplier, waits for its done,
//            writes the N*s result limbs back to BRAM and raises done_o.
// Ports    : clock_i/reset_i    - clock, async active-high reset
//            start_i / done_o   - host handshake (done_o is a level)
//            bram_*             - BRAM port B (byte address = word << 2)
//            mm_start_o/mm_done_i/res_i - multiplier handshake and result
//            M_prime_0_o/M_o/A_o/B_o    - registered operands, 17-bit limbs
// Revision : 1.0 - initial release
// ============================================================================
module amns_bram_io_ctrl #(
  parameter int N          = 5,
  parameter int s          = 4,
  parameter int RD_LATENCY = 1
) (
  input  logic                clock_i,
  input  logic                reset_i,
  input  logic                start_i,
  output logic                done_o,
  output logic                bram_en_o,
  output logic [3:0]          bram_we_o,
  output logic [31:0]         bram_addr_o,
  output logic [31:0]         bram_din_o,
  input  logic [31:0]         bram_dout_i,
  output logic                mm_start_o,
  input  logic                mm_done_i,
  output logic [N*17-1:0]     M_prime_0_o,
  output logic [N*s*17-1:0]   M_o,
  output logic [N*s*17-1:0]   A_o,
  output logic [N*s*17-1:0]   B_o,
  input  logic [N*s*17-1:0]   res_i
);

  localparam int LIMB_W = 17;
  localparam int NS     = N * s;
  localparam int TOTAL  = N + 3 * NS;
  localparam int CW     = $clog2(TOTAL + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    KICK  = 3'd2,
    WAIT  = 3'd3,
    STORE = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t                   state, state_nxt;
  logic [CW-1:0]            issue_cnt;
  logic [CW-1:0]            cap_cnt;
  logic [CW-1:0]            store_cnt;
  logic [RD_LATENCY-1:0]    vld_pipe;
  // All operand words are contiguous in BRAM, so one flat register indexed
  // by word number holds M'_0, M, A and B back to back.
  logic [TOTAL*LIMB_W-1:0]  opnd;
  logic [NS*LIMB_W-1:0]     result;
  logic                     issue_fire;
  logic                     cap_fire;
  logic                     cap_last;
  logic                     store_last;
  logic                     unused_dout;

  // Only the low 17 bits of each BRAM word carry a limb.
  assign unused_dout = &{1'b0, bram_dout_i[31:17]};

  assign issue_fire = (state == LOAD) && (issue_cnt < CW'(TOTAL));
  // A read is captured when its token reaches the end of the latency pipe,
  // so the capture point tracks RD_LATENCY without any counter arithmetic.
  assign cap_fire   = (state == LOAD) && vld_pipe[RD_LATENCY-1];
  assign cap_last   = cap_fire && (cap_cnt == CW'(TOTAL - 1));
  assign store_last = (store_cnt == CW'(NS - 1));

  assign M_prime_0_o = opnd[N*LIMB_W-1:0];
  assign M_o         = opnd[(N+NS)*LIMB_W-1   : N*LIMB_W];
  assign A_o         = opnd[(N+2*NS)*LIMB_W-1 : (N+NS)*LIMB_W];
  assign B_o         = opnd[TOTAL*LIMB_W-1    : (N+2*NS)*LIMB_W];

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    done_o      = 1'b0;
    mm_start_o  = 1'b0;
    bram_en_o   = 1'b0;
    bram_we_o   = 4'h0;
    bram_addr_o = 32'h0;
    bram_din_o  = 32'h0;
    case (state)
      IDLE: begin
        if (start_i) state_nxt = LOAD;
      end
      LOAD: begin
        if (issue_fire) begin
          bram_en_o   = 1'b1;
          bram_addr_o = {{(30-CW){1'b0}}, issue_cnt, 2'b00};
        end
        if (cap_last) state_nxt = KICK;
      end
      KICK: begin
        mm_start_o = 1'b1;
        state_nxt  = WAIT;
      end
      WAIT: begin
        if (mm_done_i) state_nxt = STORE;
      end
      STORE: begin
        bram_en_o   = 1'b1;
        bram_we_o   = 4'hf;
        bram_addr_o = {{(30-CW){1'b0}}, store_cnt, 2'b00};
        bram_din_o  = {15'b0, result[int'(store_cnt)*LIMB_W +: LIMB_W]};
        if (store_last) state_nxt = DONE;
      end
      DONE: begin
        done_o = 1'b1;
        if (start_i) state_nxt = LOAD;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      issue_cnt <= '0;
      cap_cnt   <= '0;
      store_cnt <= '0;
      vld_pipe  <= '0;
      opnd      <= '0;
      result    <= '0;
    end else begin
      vld_pipe <= (vld_pipe << 1) | RD_LATENCY'(issue_fire);
      case (state)
        IDLE, DONE: begin
          if (start_i) begin
            issue_cnt <= '0;
            cap_cnt   <= '0;
          end
        end
        LOAD: begin
          if (issue_fire) issue_cnt <= issue_cnt + CW'(1);
          if (cap_fire) begin
            opnd[int'(cap_cnt)*LIMB_W +: LIMB_W] <= bram_dout_i[16:0];
            cap_cnt <= cap_cnt + CW'(1);
          end
        end
        WAIT: begin
          // The multiplier only guarantees res_i while mm_done_i is high.
          if (mm_done_i) begin
            result    <= res_i;
            store_cnt <= '0;
          end
        end
        STORE: begin
          store_cnt <= store_cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_amns_bram_io_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_amns_bram_io_ctrl
// Purpose  : Self-checking bench. Two controllers (read latency 1 and 3) share
//            host and multiplier stimulus, each with its own BRAM model.
//            Expected operands and write-backs come from a word-array model
//            of BRAM contents.
// Revision : 1.0 - initial release
// ============================================================================
module tb_amns_bram_io_ctrl;

  localparam int N     = 5;
  localparam int S     = 4;
  localparam int NS    = N * S;
  localparam int TOTAL = N + 3 * NS;
  localparam int LW    = 17;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic mm_done = 1'b0;
  logic [NS*LW-1:0] res = '0;
  logic fill_go = 1'b0;

  always #5 clk = ~clk;

  logic              en1, en3, mms1, mms3, done1, done3;
  logic [3:0]        we1, we3;
  logic [31:0]       addr1, addr3, din1, din3, dout1, dout3;
  logic [N*LW-1:0]   mp1, mp3;
  logic [NS*LW-1:0]  m1, m3, a1, a3, b1, b3;
  logic [TOTAL*LW-1:0] ops1, ops3;
  assign ops1 = {b1, a1, m1, mp1};
  assign ops3 = {b3, a3, m3, mp3};

  amns_bram_io_ctrl #(.N(N), .s(S), .RD_LATENCY(1)) u1 (
    .clock_i(clk), .reset_i(rst), .start_i(start), .done_o(done1),
    .bram_en_o(en1), .bram_we_o(we1), .bram_addr_o(addr1), .bram_din_o(din1),
    .bram_dout_i(dout1), .mm_start_o(mms1), .mm_done_i(mm_done),
    .M_prime_0_o(mp1), .M_o(m1), .A_o(a1), .B_o(b1), .res_i(res)
  );

  amns_bram_io_ctrl #(.N(N), .s(S), .RD_LATENCY(3)) u3 (
    .clock_i(clk), .reset_i(rst), .start_i(start), .done_o(done3),
    .bram_en_o(en3), .bram_we_o(we3), .bram_addr_o(addr3), .bram_din_o(din3),
    .bram_dout_i(dout3), .mm_start_o(mms3), .mm_done_i(mm_done),
    .M_prime_0_o(mp3), .M_o(m3), .A_o(a3), .B_o(b3), .res_i(res)
  );

  // BRAM models; port A is a bulk copy of pat[] on fill_go
  logic [31:0] pat  [0:127];
  logic [31:0] emem [0:127];
  logic [31:0] mem1 [0:127];
  logic [31:0] mem3 [0:127];
  logic [31:0] rd1, rd3a, rd3b, rd3c;

  always @(posedge clk) begin
    if (fill_go) begin
      for (int k = 0; k < 128; k++) mem1[k] <= pat[k];
    end else if (en1) begin
      for (int b = 0; b < 4; b++)
        if (we1[b]) mem1[addr1[8:2]][b*8 +: 8] <= din1[b*8 +: 8];
      rd1 <= mem1[addr1[8:2]];
    end
  end
  assign dout1 = rd1;

  always @(posedge clk) begin
    if (fill_go) begin
      for (int k = 0; k < 128; k++) mem3[k] <= pat[k];
    end else if (en3) begin
      for (int b = 0; b < 4; b++)
        if (we3[b]) mem3[addr3[8:2]][b*8 +: 8] <= din3[b*8 +: 8];
      rd3a <= mem3[addr3[8:2]];
    end
    rd3b <= rd3a;
    rd3c <= rd3b;
  end
  assign dout3 = rd3c;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int limb_err(input logic [TOTAL*LW-1:0] ops);
    int e = 0;
    for (int k = 0; k < TOTAL; k++)
      if (ops[k*LW +: LW] !== emem[k][16:0]) e++;
    return e;
  endfunction

  function automatic int mem_err();
    int e = 0;
    for (int k = 0; k < TOTAL; k++)
      if (mem1[k] !== emem[k] || mem3[k] !== emem[k]) e++;
    return e;
  endfunction

  task automatic fill(input int kind);
    for (int k = 0; k < 128; k++) begin
      case (kind)
        0:       pat[k] = (k < TOTAL) ? 32'h10000 + 32'(k) : 32'h0;
        1:       pat[k] = 32'hFFFE_0003;
        default: pat[k] = $urandom;
      endcase
      emem[k] = pat[k];
    end
    @(negedge clk); fill_go = 1'b1;
    @(negedge clk); fill_go = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_ctl"}, {56'b0, en1, we1, mms1, done1, en3, we3, mms3, done3}, 64'h0);
    chk({tag, "_addr_din"}, {addr1 | addr3, din1 | din3}, 64'h0);
  endtask

  // Asserts reset between edges and checks that everything clears at once.
  task automatic async_reset(input string tag);
    start = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_quiet({tag, "_async"});
    chk({tag, "_ops_zero"}, {63'b0, |(ops1 | ops3)}, 64'h0);
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);
    check_quiet({tag, "_idle_after"});
  endtask

  task automatic full_run(input string tag, input bit poke, input bit ramp,
                          input int rst_load, input int rst_store, input int mm_delay);
    int err, ms1, ms3, n1, n3;
    logic [NS*LW-1:0] r;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    err = 0; ms1 = -1; ms3 = -1; n1 = 0; n3 = 0;
    // d=0 is the cycle right after the start edge
    for (int d = 0; d < TOTAL + 8; d++) begin
      if (d == rst_load) begin
        async_reset(tag);
        return;
      end
      if (en1 !== (d < TOTAL) || en3 !== (d < TOTAL)) err++;
      if (d < TOTAL && (addr1 !== 32'(d * 4) || addr3 !== 32'(d * 4))) err++;
      if (we1 !== 4'h0 || we3 !== 4'h0 || done1 !== 1'b0 || done3 !== 1'b0) err++;
      if (mms1) begin n1++; if (ms1 < 0) ms1 = d; end
      if (mms3) begin n3++; if (ms3 < 0) ms3 = d; end
      mm_done = (d == 10);  // stray done while loading must be ignored
      @(negedge clk);
    end
    mm_done = 1'b0;
    chk({tag, "_load_seq"}, err, 0);
    chk({tag, "_kick_lat1_at"}, ms1, TOTAL + 1);
    chk({tag, "_kick_lat3_at"}, ms3, TOTAL + 3);
    chk({tag, "_kick_pulses"}, {n1, n3}, {32'd1, 32'd1});
    chk({tag, "_ops_lat1"}, limb_err(ops1), 0);
    chk({tag, "_ops_lat3"}, limb_err(ops3), 0);

    err = 0;
    for (int w = 0; w < mm_delay; w++) begin
      if (en1 | en3 | mms1 | mms3 | done1 | done3) err++;
      start = poke && (w == mm_delay / 2);
      @(negedge clk);
    end
    start = 1'b0;
    chk({tag, "_wait_quiet"}, err, 0);

    for (int j = 0; j < NS; j++)
      r[j*LW +: LW] = ramp ? 17'h1FFFF - 17'(j) : 17'($urandom);
    res = r; mm_done = 1'b1;
    @(negedge clk);
    mm_done = 1'b0; res = ~r;  // write-back must come from the latched copy
    err = 0;
    for (int j = 0; j < NS; j++) begin
      if (j == rst_store) begin
        for (int q = 0; q < j; q++) emem[q] = {15'b0, r[q*LW +: LW]};
        async_reset(tag);
        chk({tag, "_partial_mem"}, mem_err(), 0);
        return;
      end
      if (en1 !== 1'b1 || we1 !== 4'hf || addr1 !== 32'(j * 4) ||
          din1 !== {15'b0, r[j*LW +: LW]}) err++;
      if (en3 !== 1'b1 || we3 !== 4'hf || addr3 !== 32'(j * 4) ||
          din3 !== {15'b0, r[j*LW +: LW]}) err++;
      if (done1 | done3) err++;
      start = poke && (j == 5);
      @(negedge clk);
    end
    start = 1'b0;
    chk({tag, "_store_seq"}, err, 0);
    chk({tag, "_done_rise"}, {52'b0, done1, done3, en1, en3, we1, we3}, {52'b0, 12'b1100_0000_0000});
    for (int q = 0; q < NS; q++) emem[q] = {15'b0, r[q*LW +: LW]};
    chk({tag, "_mem"}, mem_err(), 0);
    repeat (4) @(negedge clk);
    chk({tag, "_done_held"}, {62'b0, done1, done3}, 64'h3);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 128; k++) begin pat[k] = 32'h0; emem[k] = 32'h0; end
    repeat (3) @(negedge clk);
    check_quiet("reset");
    chk("reset_ops_zero", {63'b0, |(ops1 | ops3)}, 64'h0);
    rst = 1'b0;

    fill(0);
    full_run("ramp", 1'b1, 1'b1, -1, -1, 200);
    chk("ramp_lat1_limbs", {13'b0, mp1[0 +: LW], mp1[4*LW +: LW], a1[0 +: LW]},
        {13'b0, 17'h10000, 17'h10004, 17'h10019});
    chk("ramp_lat1_b19", {47'b0, b1[19*LW +: LW]}, {47'b0, 17'h10040});
    chk("ramp_lat3_limbs", {13'b0, mp3[0 +: LW], mp3[4*LW +: LW], a3[0 +: LW]},
        {13'b0, 17'h10000, 17'h10004, 17'h10019});
    chk("ramp_lat3_b19", {47'b0, b3[19*LW +: LW]}, {47'b0, 17'h10040});

    full_run("rerun_from_done", 1'b0, 1'b0, -1, -1, 37);

    fill(1);
    full_run("mask", 1'b0, 1'b0, -1, -1, 5);
    chk("mask_limb", {30'b0, a1[7*LW +: LW], b3[3*LW +: LW]}, {30'b0, 17'h3, 17'h3});

    full_run("rst_load", 1'b0, 1'b0, 30, -1, 0);
    full_run("after_rst_load", 1'b0, 1'b0, -1, -1, 20);

    fill(2);
    full_run("rand", 1'b1, 1'b0, -1, -1, int'($urandom_range(1, 60)));
    full_run("rst_store", 1'b0, 1'b0, -1, 7, 10);
    full_run("after_rst_store", 1'b0, 1'b0, -1, -1, 15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
